// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, requester indices and arbiter state type
package uart_pkg;

    // Requester slots on the UART transmit arbiter
    localparam int REQ_CMD_REPLY = 0;
    localparam int REQ_STATUS    = 1;
    localparam int REQ_DEBUG     = 2;

    // Stall cycles tolerated from a packet owner before its packet is dropped
    localparam int ARB_TIMEOUT_DEFAULT = 4096;

    // Serial line timing, shared with the serializer
    localparam int CLK_HZ         = 50_000_000;
    localparam int BAUD           = 115_200;
    localparam int BITS_PER_FRAME = 10;

    // Clocks per transmitted byte: rounded bit period times start+8 data+stop bits
    function automatic int byte_time(input int clk_hz, input int baud);
        return ((clk_hz + baud / 2) / baud) * BITS_PER_FRAME;
    endfunction

    localparam int BYTE_TIME_CLKS = byte_time(CLK_HZ, BAUD);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority encoder starting after ptr
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);

    logic          found;
    logic [PW-1:0] cand;

    // Walk ptr+1, ptr+2, ... wrapping modulo N_REQ; the first active request wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-level round-robin arbiter for the UART transmit byte path
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PTR_RESET  = PW'(N_REQ - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              terr_q, terr_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              xfer;
    logic              own_valid;
    logic              own_last;
    logic [7:0]        own_data;
    logic              handshake;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Owner's byte stream is passed straight through while a packet is open
    assign xfer      = (state_q == ARB_XFER);
    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_data  = req_data[8*owner_q +: 8];
    assign handshake = xfer & own_valid & tx_ready;

    assign tx_valid    = xfer & own_valid;
    assign tx_data     = xfer ? own_data : 8'h00;
    assign req_ready   = grant_q & {N_REQ{tx_ready}};
    assign grant       = grant_q;
    assign busy        = xfer;
    assign timeout_err = terr_q;

    // Next-state: pick an owner when idle, close the packet on last byte or stall timeout
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        stall_d = stall_q;
        terr_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_d = ARB_XFER;
                    owner_d = pick_idx;
                    grant_d = pick_gnt;
                    stall_d = '0;
                end
            end
            ARB_XFER: begin
                if (handshake) begin
                    stall_d = '0;
                    if (own_last) begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_q;
                        grant_d = '0;
                    end
                end else if (!own_valid) begin
                    // Backpressure with a valid byte holds the counter; only owner silence counts
                    if (stall_q == STALL_LAST) begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_q;
                        grant_d = '0;
                        stall_d = '0;
                        terr_d  = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset parks ptr on the last index so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_RESET;
            grant_q <= '0;
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam logic [N-1:0] ONE = 1;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    int total = 0;
    int bad   = 0;

    // Per-requester byte queues: bit 8 is the last flag
    logic [8:0] rq [N][$];
    logic [N-1:0] hold;

    logic [N-1:0] o_grant, o_ready, o_hs;
    logic [7:0]   o_data;
    logic         o_valid, o_busy, o_terr, o_last, o_txr;

    uart_tx_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic apply_inputs();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && !hold[i]) begin
                h = rq[i][0];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]       = h[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        o_grant = grant;
        o_ready = req_ready;
        o_data  = tx_data;
        o_valid = tx_valid;
        o_busy  = busy;
        o_terr  = timeout_err;
        o_txr   = tx_ready;
        o_hs    = req_valid & req_ready;
        o_last  = |(req_last & o_hs);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (o_hs[i]) void'(rq[i].pop_front());
        apply_inputs();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq[i].delete();
        hold     = '0;
        tx_ready = 1'b0;
        resetn   = 1'b0;
        apply_inputs();
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        total++; if (o_grant !== '0) begin bad++; $display("FAIL reset.grant got=%b exp=000", o_grant); end
        total++; if (o_ready !== '0) begin bad++; $display("FAIL reset.req_ready got=%b exp=000", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset.tx_valid got=%b exp=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b exp=0", o_busy); end
        total++; if (o_terr !== 1'b0) begin bad++; $display("FAIL reset.timeout_err got=%b exp=0", o_terr); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset.tx_data got=%h exp=00", o_data); end
    endtask

    task automatic test_single_packet();
        logic [7:0] ex [3];
        ex = '{8'h41, 8'h42, 8'h43};
        do_reset();
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) rq[1].push_back({(k == 2), ex[k]});
        apply_inputs();
        cycle();
        total++; if (o_grant !== 3'b000) begin bad++; $display("FAIL single.decision_grant got=%b exp=000", o_grant); end
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++; if (o_grant !== 3'b010) begin bad++; $display("FAIL single.grant c=%0d got=%b exp=010", c, o_grant); end
            total++; if (o_valid !== 1'b1 || o_data !== ex[c]) begin bad++; $display("FAIL single.data c=%0d got=%b/%h exp=1/%h", c, o_valid, o_data, ex[c]); end
            total++; if (o_ready !== 3'b010) begin bad++; $display("FAIL single.req_ready c=%0d got=%b exp=010", c, o_ready); end
        end
        cycle();
        total++; if (o_busy !== 1'b0 || o_grant !== 3'b000) begin bad++; $display("FAIL single.busy_drop got=%b/%b exp=0/000", o_busy, o_grant); end
    endtask

    task automatic test_two_contenders();
        int         eo [7];
        logic [7:0] ed [7];
        logic [7:0] b [4];
        logic [N-1:0] eg;
        for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
        do_reset();
        tx_ready = 1'b1;
        rq[0].push_back({1'b0, b[0]}); rq[0].push_back({1'b1, b[1]});
        rq[2].push_back({1'b0, b[2]}); rq[2].push_back({1'b1, b[3]});
        apply_inputs();
        eo = '{-1, 0, 0, -1, 2, 2, -1};
        ed = '{8'h00, b[0], b[1], 8'h00, b[2], b[3], 8'h00};
        for (int c = 0; c < 7; c++) begin
            cycle();
            eg = (eo[c] < 0) ? '0 : (ONE << eo[c]);
            total++; if (o_grant !== eg) begin bad++; $display("FAIL two.grant c=%0d got=%b exp=%b", c, o_grant, eg); end
            if (eo[c] >= 0) begin
                total++; if (o_valid !== 1'b1 || o_data !== ed[c]) begin bad++; $display("FAIL two.data c=%0d got=%b/%h exp=1/%h", c, o_valid, o_data, ed[c]); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [7:0]   eb;
        int           own;
        do_reset();
        tx_ready = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(16 * i + k)});
        apply_inputs();
        for (int c = 0; c < 12; c++) begin
            cycle();
            own = (c / 2) % N;
            eg  = (c % 2 == 0) ? '0 : (ONE << own);
            total++; if (o_grant !== eg) begin bad++; $display("FAIL rr.grant c=%0d got=%b exp=%b", c, o_grant, eg); end
            if (c % 2 == 1) begin
                eb = 8'(16 * own + (c / 2) / N);
                total++; if (o_data !== eb || o_last !== 1'b1) begin bad++; $display("FAIL rr.data c=%0d got=%h/%b exp=%h/1", c, o_data, o_last, eb); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        int n_terr = 0, n_novalid = 0, n_hs = 0;
        b = 8'($urandom);
        do_reset();
        tx_ready = 1'b0;
        rq[1].push_back({1'b1, b});
        apply_inputs();
        cycle();
        for (int c = 0; c < 10000; c++) begin
            cycle();
            if (o_terr) n_terr++;
            if (!o_valid) n_novalid++;
            if (o_hs != '0) n_hs++;
        end
        total++; if (n_terr !== 0) begin bad++; $display("FAIL bp.no_timeout got=%0d exp=0", n_terr); end
        total++; if (n_novalid !== 0) begin bad++; $display("FAIL bp.valid_held got=%0d exp=0", n_novalid); end
        total++; if (n_hs !== 0) begin bad++; $display("FAIL bp.no_handshake got=%0d exp=0", n_hs); end
        total++; if (o_grant !== 3'b010) begin bad++; $display("FAIL bp.grant got=%b exp=010", o_grant); end
        tx_ready = 1'b1;
        cycle();
        total++; if (o_hs !== 3'b010 || o_data !== b) begin bad++; $display("FAIL bp.release got=%b/%h exp=010/%h", o_hs, o_data, b); end
        cycle();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL bp.busy_after got=%b exp=0", o_busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] x, y, z;
        int n_terr = 0, n_idle = 0;
        x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
        do_reset();
        tx_ready = 1'b1;
        rq[0].push_back({1'b0, x}); rq[0].push_back({1'b1, y});
        rq[2].push_back({1'b1, z});
        apply_inputs();
        cycle();
        total++; if (o_grant !== 3'b000) begin bad++; $display("FAIL to.decision got=%b exp=000", o_grant); end
        cycle();
        total++; if (o_hs !== 3'b001 || o_data !== x) begin bad++; $display("FAIL to.first_byte got=%b/%h exp=001/%h", o_hs, o_data, x); end
        hold[0] = 1'b1;
        apply_inputs();
        for (int s = 0; s < TO; s++) begin
            cycle();
            if (o_terr) n_terr++;
            if (!o_busy) n_idle++;
        end
        total++; if (n_terr !== 0) begin bad++; $display("FAIL to.early_pulse got=%0d exp=0", n_terr); end
        total++; if (n_idle !== 0) begin bad++; $display("FAIL to.early_abort got=%0d exp=0", n_idle); end
        hold[0] = 1'b0;
        apply_inputs();
        cycle();
        total++; if (o_terr !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL to.pulse got=%b/%b exp=1/0", o_terr, o_busy); end
        cycle();
        total++; if (o_grant !== 3'b100 || o_data !== z || o_terr !== 1'b0) begin bad++; $display("FAIL to.next_owner got=%b/%h/%b exp=100/%h/0", o_grant, o_data, o_terr, z); end
        cycle();
        if (o_terr) n_terr++;
        cycle();
        if (o_terr) n_terr++;
        total++; if (o_grant !== 3'b001 || o_data !== y || o_last !== 1'b1) begin bad++; $display("FAIL to.rest_as_new got=%b/%h/%b exp=001/%h/1", o_grant, o_data, o_last, y); end
        total++; if (n_terr !== 0) begin bad++; $display("FAIL to.single_pulse got=%0d extra exp=0", n_terr); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) rq[2].push_back({(k == 3), 8'($urandom)});
        apply_inputs();
        cycle();
        cycle();
        cycle();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rst.mid_busy got=%b exp=1", o_busy); end
        rq[0].push_back({1'b1, 8'hA0});
        rq[1].push_back({1'b1, 8'hB1});
        apply_inputs();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        total++; if (o_grant !== 3'b000 || o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rst.after got=%b/%b/%b exp=000/0/0", o_grant, o_valid, o_busy); end
        cycle();
        total++; if (o_grant !== 3'b001 || o_data !== 8'hA0) begin bad++; $display("FAIL rst.first_winner got=%b/%h exp=001/a0", o_grant, o_data); end
    endtask

    task automatic test_random();
        logic [8:0] mq [N][$];
        int         e_own [$];
        logic [8:0] e_byte [$];
        logic [8:0] h;
        int p, sel, npk, len, budget, obs_own;
        logic found;
        do_reset();
        for (int i = 0; i < N; i++) begin
            npk = $urandom_range(1, 3);
            for (int k = 0; k < npk; k++) begin
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) rq[i].push_back({(j == len - 1), 8'($urandom)});
            end
            mq[i] = rq[i];
        end
        // Reference: whole packets in round-robin order over requesters with work left
        p = N - 1;
        while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
            found = 1'b0;
            sel   = 0;
            for (int k = 1; k <= N; k++)
                if (!found && mq[(p + k) % N].size() > 0) begin
                    found = 1'b1;
                    sel   = (p + k) % N;
                end
            do begin
                h = mq[sel].pop_front();
                e_own.push_back(sel);
                e_byte.push_back(h);
            end while (!h[8]);
            p = sel;
        end
        apply_inputs();
        budget = 0;
        while (pending() > 0 && budget < 3000) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            cycle();
            budget++;
            total++; if ($countones(o_ready) > 1) begin bad++; $display("FAIL rand.ready_onehot got=%b exp=at most one", o_ready); end
            total++; if ((o_hs != '0) !== (o_valid & o_txr)) begin bad++; $display("FAIL rand.hs_consistent got=%b exp=%b", (o_hs != '0), o_valid & o_txr); end
            total++; if (o_terr !== 1'b0) begin bad++; $display("FAIL rand.timeout got=%b exp=0", o_terr); end
            if (o_hs != '0) begin
                obs_own = 0;
                for (int i = 0; i < N; i++) if (o_hs[i]) obs_own = i;
                total++;
                if (e_own.size() == 0) begin
                    bad++; $display("FAIL rand.extra_byte got=%h exp=none", o_data);
                end else begin
                    sel = e_own.pop_front();
                    h   = e_byte.pop_front();
                    if (obs_own !== sel || o_data !== h[7:0] || o_last !== h[8] || o_grant !== (ONE << sel)) begin
                        bad++;
                        $display("FAIL rand.stream got=%0d/%h/%b/%b exp=%0d/%h/%b", obs_own, o_data, o_last, o_grant, sel, h[7:0], h[8]);
                    end
                end
            end
        end
        total++; if (pending() != 0) begin bad++; $display("FAIL rand.budget got=%0d bytes left exp=0", pending()); end
        total++; if (e_own.size() != 0) begin bad++; $display("FAIL rand.missing got=%0d bytes unseen exp=0", e_own.size()); end
    endtask

    initial begin
        resetn    = 1'b0;
        tx_ready  = 1'b0;
        hold      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single_packet();
        test_two_contenders();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        for (int r = 0; r < 4; r++) test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
